// File: rtl/rsa_ram_pkg.sv
// Shared definitions for the RSA RAM port arbiter: requester indices,
// the one-hot grant vector type and a small grant decode helper.
package rsa_ram_pkg;

    // Number of requesters sharing the RAM
    localparam int REQ_N    = 2;

    // Requester indices
    localparam int REQ_CORE = 0;   // IDDMM core
    localparam int REQ_HOST = 1;   // host operand loader

    // One-hot grant vector, bit i set when requester i owns the channel
    typedef logic [REQ_N-1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_CORE = 2'b01;
    localparam grant_t GRANT_HOST = 2'b10;
    localparam grant_t GRANT_BOTH = 2'b11;

    // Index of the granted requester; an empty grant decodes to the core so
    // that idle-channel muxes still select a defined payload.
    function automatic logic grant_idx(input grant_t g);
        logic idx;
        idx = g[REQ_HOST];
        return idx;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the RAM port arbiter: packed write and read
// request channels of both requesters plus the shared read response bus.
// master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
    parameter int WIDTH   = 64,
    parameter int WIDTHAD = 7
);
    import rsa_ram_pkg::*;

    // Write channel, requester i payload at [i*W +: W]
    logic [REQ_N-1:0]         wr_valid;
    grant_t                   wr_ready;
    logic [REQ_N*WIDTHAD-1:0] wr_addr;
    logic [REQ_N*WIDTH-1:0]   wr_data;

    // Read request channel
    logic [REQ_N-1:0]         rd_valid;
    grant_t                   rd_ready;
    logic [REQ_N*WIDTHAD-1:0] rd_addr;

    // Read response, one-hot strobe on a shared data bus
    grant_t                   rd_rvalid;
    logic [WIDTH-1:0]         rd_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr,
        input  wr_ready, rd_ready,
        input  rd_rvalid, rd_rdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr,
        output wr_ready, rd_ready,
        output rd_rvalid, rd_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational from the request
// vector and a one-bit priority pointer; the pointer flips to the other
// requester only when a granted transfer takes place (advance_i).
module rr_arb2
    import rsa_ram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_N-1:0] req_i,
    input  logic             advance_i,
    output grant_t           grant_o
);

    // 0: core favoured on contention, 1: host favoured
    logic ptr_q;
    logic ptr_d;

    // Grant selection; forced empty while reset is asserted
    always_comb begin
        grant_o = GRANT_NONE;
        if (rst) begin
            grant_o = GRANT_NONE;
        end else begin
            case (req_i)
                GRANT_CORE: grant_o = GRANT_CORE;
                GRANT_HOST: grant_o = GRANT_HOST;
                GRANT_BOTH: grant_o = ptr_q ? GRANT_HOST : GRANT_CORE;
                default:    grant_o = GRANT_NONE;
            endcase
        end
    end

    // Pointer next state: after a transfer, favour the requester that lost
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (grant_o != GRANT_NONE)) begin
            ptr_d = ~grant_idx(grant_o);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register, restarts favouring the core
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM (one write port, one registered read port)
// between the IDDMM core (requester 0) and the host operand loader
// (requester 1). Write and read channels are arbitrated independently with
// their own round-robin arbiter; read data returns to the granted requester
// exactly one cycle after the grant.
//
// Optional feature macro: RAM_ARB_RD_BYPASS_EN
//   defined   - a read granted in the same cycle as a write to the same
//               address returns the newly written data (write-first).
//   undefined - such a read returns the old RAM contents (read-first) and no
//               extra registers are built.
module ram_port_arbiter
    import rsa_ram_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int WIDTHAD = 7
) (
    input  logic               clk,
    input  logic               rst,
    ram_port_arbiter_if.slave  req_if,
    output logic               ram_wren_o,
    output logic [WIDTHAD-1:0] ram_wraddress_o,
    output logic [WIDTH-1:0]   ram_data_o,
    output logic [WIDTHAD-1:0] ram_rdaddress_o,
    input  logic [WIDTH-1:0]   ram_q_i
);

    grant_t             wr_grant_s;
    grant_t             rd_grant_s;
    logic               wr_fire_s;
    logic               rd_fire_s;
    grant_t             rsp_sel_d;
    grant_t             rsp_sel_q;
    logic [WIDTH-1:0]   rd_data_s;
    grant_t             rd_rvalid_s;
    logic [WIDTH-1:0]   rd_rdata_s;

    // ------------------------------------------------------------------
    // Arbiters
    // ------------------------------------------------------------------
    rr_arb2 u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_if.wr_valid),
        .advance_i (wr_fire_s),
        .grant_o   (wr_grant_s)
    );

    rr_arb2 u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_if.rd_valid),
        .advance_i (rd_fire_s),
        .grant_o   (rd_grant_s)
    );

    assign req_if.wr_ready = wr_grant_s;
    assign req_if.rd_ready = rd_grant_s;

    // Transfer detection on both channels
    always_comb begin
        wr_fire_s = |(req_if.wr_valid & wr_grant_s);
        rd_fire_s = |(req_if.rd_valid & rd_grant_s);
    end

    // ------------------------------------------------------------------
    // Write path: winner's payload always drives the RAM, wren gates it
    // ------------------------------------------------------------------

    // Write port mux
    always_comb begin
        ram_wren_o = wr_fire_s;
        if (grant_idx(wr_grant_s) == 1'b1) begin
            ram_wraddress_o = req_if.wr_addr[REQ_HOST*WIDTHAD +: WIDTHAD];
            ram_data_o      = req_if.wr_data[REQ_HOST*WIDTH +: WIDTH];
        end else begin
            ram_wraddress_o = req_if.wr_addr[REQ_CORE*WIDTHAD +: WIDTHAD];
            ram_data_o      = req_if.wr_data[REQ_CORE*WIDTH +: WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Read address mux
    always_comb begin
        if (grant_idx(rd_grant_s) == 1'b1) begin
            ram_rdaddress_o = req_if.rd_addr[REQ_HOST*WIDTHAD +: WIDTHAD];
        end else begin
            ram_rdaddress_o = req_if.rd_addr[REQ_CORE*WIDTHAD +: WIDTHAD];
        end
    end

    // Response owner for the data the RAM returns next cycle
    always_comb begin
        rsp_sel_d = GRANT_NONE;
        if (rd_fire_s) begin
            rsp_sel_d = rd_grant_s;
        end else begin
            rsp_sel_d = GRANT_NONE;
        end
    end

    // Response owner register; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sel_q <= GRANT_NONE;
        end else begin
            rsp_sel_q <= rsp_sel_d;
        end
    end

`ifdef RAM_ARB_RD_BYPASS_EN
    logic             hit_d;
    logic             hit_q;
    logic [WIDTH-1:0] byp_data_q;

    // Same-cycle write/read collision on one address
    always_comb begin
        hit_d = wr_fire_s & rd_fire_s & (ram_wraddress_o == ram_rdaddress_o);
    end

    // Remember the colliding write data for the response cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            hit_q <= hit_d;
            if (hit_d) begin
                byp_data_q <= ram_data_o;
            end
        end
    end

    // Collision returns the fresh write data instead of the stale RAM word
    always_comb begin
        if (hit_q) begin
            rd_data_s = byp_data_q;
        end else begin
            rd_data_s = ram_q_i;
        end
    end
`else
    // RAM output passes straight through (read-first on collision)
    always_comb begin
        rd_data_s = ram_q_i;
    end
`endif

    // Response bus; quiet while in reset or with nothing in flight
    always_comb begin
        rd_rvalid_s = GRANT_NONE;
        rd_rdata_s  = '0;
        if (rst) begin
            rd_rvalid_s = GRANT_NONE;
            rd_rdata_s  = '0;
        end else if (rsp_sel_q != GRANT_NONE) begin
            rd_rvalid_s = rsp_sel_q;
            rd_rdata_s  = rd_data_s;
        end else begin
            rd_rvalid_s = GRANT_NONE;
            rd_rdata_s  = '0;
        end
    end

    assign req_if.rd_rvalid = rd_rvalid_s;
    assign req_if.rd_rdata  = rd_rdata_s;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM, a shadow memory
// and a response scoreboard. Build with +define+RAM_ARB_RD_BYPASS_EN to
// exercise the write-first collision behaviour.
module tb_ram_port_arbiter;
    import rsa_ram_pkg::*;

    localparam int W  = 64;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.WIDTH(W), .WIDTHAD(AW)) bus ();

    logic          ram_wren;
    logic [AW-1:0] ram_wraddress;
    logic [W-1:0]  ram_data;
    logic [AW-1:0] ram_rdaddress;
    logic [W-1:0]  ram_q;

    ram_port_arbiter #(.WIDTH(W), .WIDTHAD(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_if          (bus),
        .ram_wren_o      (ram_wren),
        .ram_wraddress_o (ram_wraddress),
        .ram_data_o      (ram_data),
        .ram_rdaddress_o (ram_rdaddress),
        .ram_q_i         (ram_q)
    );

    // Behavioural simple dual-port RAM, registered read, read-first
    logic [W-1:0] mem [0:127];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [1:0]  sel;
        logic [W-1:0] data;
        bit          chk_data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [W-1:0] shadow [0:127];
    bit           known  [0:127];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] onehot(input int r);
        return (r == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic exp_push(input int r, input logic [W-1:0] d, input bit k);
        exp_t e;
        e.cyc = cyc + 1;
        e.sel = onehot(r);
        e.data = d;
        e.chk_data = k;
        sb.push_back(e);
    endtask

    // Response monitor: every strobe must match the oldest expectation
    always @(negedge clk) begin
        if (bus.rd_rvalid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(bus.rd_rvalid), 64'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("rsp_sel", 64'(bus.rd_rvalid), 64'(mon_e.sel));
                if (mon_e.chk_data) chk("rsp_data", bus.rd_rdata, mon_e.data);
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            chk("rsp_missing", 64'h0, 64'(mon_e.sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 2'b00;
        bus.rd_valid = 2'b00;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
    endtask

    task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.wr_valid[r]          = 1'b1;
        bus.wr_addr[r*AW +: AW]  = a;
        bus.wr_data[r*W +: W]    = d;
    endtask

    task automatic set_rd(input int r, input logic [AW-1:0] a);
        bus.rd_valid[r]         = 1'b1;
        bus.rd_addr[r*AW +: AW] = a;
    endtask

    task automatic do_write(input int r, input logic [AW-1:0] a, input logic [W-1:0] d);
        set_wr(r, a, d);
        @(negedge clk);
        chk("wr_ready", 64'(bus.wr_ready), 64'(onehot(r)));
        chk("ram_wraddress", 64'(ram_wraddress), 64'(a));
        chk("ram_data", ram_data, d);
        shadow[a] = d;
        known[a]  = 1'b1;
        tick();
        bus.wr_valid = 2'b00;
    endtask

    task automatic do_read(input int r, input logic [AW-1:0] a);
        set_rd(r, a);
        @(negedge clk);
        chk("rd_ready", 64'(bus.rd_ready), 64'(onehot(r)));
        chk("ram_rdaddress", 64'(ram_rdaddress), 64'(a));
        exp_push(r, shadow[a], known[a]);
        tick();
        bus.rd_valid = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a0, a1;
        logic [1:0]    gexp;
        logic [W-1:0]  hz_exp;
        int            i0, i1;

        for (int i = 0; i < 128; i++) begin
            shadow[i] = '0;
            known[i]  = 1'b0;
        end
        idle_inputs();

        // 1. Reset with every requester asking
        set_wr(0, 7'h7F, 64'hDEAD);
        set_wr(1, 7'h7E, 64'hBEEF);
        set_rd(0, 7'h40);
        set_rd(1, 7'h41);
        repeat (3) begin
            @(negedge clk);
            chk("rst_wr_ready", 64'(bus.wr_ready), 64'h0);
            chk("rst_rd_ready", 64'(bus.rd_ready), 64'h0);
            chk("rst_ram_wren", 64'(ram_wren), 64'h0);
            chk("rst_rd_rvalid", 64'(bus.rd_rvalid), 64'h0);
            chk("rst_rd_rdata", bus.rd_rdata, 64'h0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_ready", 64'(bus.wr_ready), 64'h1);
        chk("post_rst_rd_ready", 64'(bus.rd_ready), 64'h1);
        chk("post_rst_wraddr", 64'(ram_wraddress), 64'h7F);
        shadow[7'h7F] = 64'hDEAD;
        known[7'h7F]  = 1'b1;
        exp_push(0, shadow[7'h40], known[7'h40]);
        tick();
        idle_inputs();

        // Host write moves the write pointer back to favour the core
        do_write(1, 7'h7E, 64'hBEEF);

        // 2. Write contention: grants alternate core, host, core, host
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 4; k++) begin
            a0 = 7'h10 + 7'(i0);
            a1 = 7'h20 + 7'(i1);
            set_wr(0, a0, 64'h1000 + 64'(a0));
            set_wr(1, a1, 64'h2000 + 64'(a1));
            @(negedge clk);
            gexp = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("contention_grant", 64'(bus.wr_ready), 64'(gexp));
            if (gexp == 2'b01) begin
                chk("contention_addr", 64'(ram_wraddress), 64'(a0));
                shadow[a0] = 64'h1000 + 64'(a0);
                known[a0]  = 1'b1;
                i0++;
            end else begin
                chk("contention_addr", 64'(ram_wraddress), 64'(a1));
                shadow[a1] = 64'h2000 + 64'(a1);
                known[a1]  = 1'b1;
                i1++;
            end
            tick();
        end
        bus.wr_valid = 2'b00;
        do_read(0, 7'h10);
        do_read(1, 7'h11);
        do_read(0, 7'h20);
        do_read(1, 7'h21);

        // Preload 0..7 for streaming
        for (int i = 0; i < 8; i++) do_write(0, 7'(i), 64'h0100 + 64'(i));

        // 4. Streaming reads, one per cycle, host idle
        for (int i = 0; i < 8; i++) begin
            set_rd(0, 7'(i));
            @(negedge clk);
            chk("stream_rd_ready", 64'(bus.rd_ready), 64'h1);
            exp_push(0, shadow[i], known[i]);
            tick();
        end
        bus.rd_valid = 2'b00;

        // 3. Read latency for the host
        do_write(1, 7'h05, 64'hA5A5);
        do_read(1, 7'h05);

        // Simultaneous write and read on different addresses
        set_wr(0, 7'h08, 64'h0808);
        set_rd(1, 7'h10);
        @(negedge clk);
        chk("wr_rd_wr_ready", 64'(bus.wr_ready), 64'h1);
        chk("wr_rd_rd_ready", 64'(bus.rd_ready), 64'h2);
        exp_push(1, shadow[7'h10], known[7'h10]);
        shadow[7'h08] = 64'h0808;
        known[7'h08]  = 1'b1;
        tick();
        idle_inputs();
        do_read(0, 7'h08);

        // 5. Same-address write/read collision
        do_write(0, 7'h03, 64'hFFFF);
        set_wr(0, 7'h03, 64'h1234);
        set_rd(1, 7'h03);
        @(negedge clk);
        chk("hazard_wr_ready", 64'(bus.wr_ready), 64'h1);
        chk("hazard_rd_ready", 64'(bus.rd_ready), 64'h2);
`ifdef RAM_ARB_RD_BYPASS_EN
        hz_exp = 64'h1234;
`else
        hz_exp = 64'hFFFF;
`endif
        exp_push(1, hz_exp, 1'b1);
        shadow[7'h03] = 64'h1234;
        tick();
        idle_inputs();
        do_read(1, 7'h10);
        do_read(0, 7'h03);

        // 6. Reset the cycle after a read grant
        set_rd(0, 7'h11);
        @(negedge clk);
        chk("midrst_rd_ready", 64'(bus.rd_ready), 64'h1);
        tick();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rd_rvalid", 64'(bus.rd_rvalid), 64'h0);
        chk("midrst_rd_rdata", bus.rd_rdata, 64'h0);
        tick();
        rst = 1'b0;
        set_wr(0, 7'h30, 64'h3030);
        set_wr(1, 7'h31, 64'h3131);
        set_rd(0, 7'h20);
        set_rd(1, 7'h21);
        @(negedge clk);
        chk("midrst_wr_first", 64'(bus.wr_ready), 64'h1);
        chk("midrst_rd_first", 64'(bus.rd_ready), 64'h1);
        exp_push(0, shadow[7'h20], known[7'h20]);
        shadow[7'h30] = 64'h3030;
        known[7'h30]  = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_wr_second", 64'(bus.wr_ready), 64'h2);
        chk("midrst_rd_second", 64'(bus.rd_ready), 64'h2);
        exp_push(1, shadow[7'h21], known[7'h21]);
        shadow[7'h31] = 64'h3131;
        known[7'h31]  = 1'b1;
        tick();
        idle_inputs();
        do_read(0, 7'h30);
        do_read(1, 7'h31);

        repeat (3) tick();
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
